// File: rtl/mst_ch_sched_pkg.sv
// mst_pkg: shared types and constants for the multi-channel streaming scheduler.
//   sched_st_t      - scheduler state encoding (IDLE, ARB, XFER, GAP)
//   CNT_CHANNLS_DEF - default number of scheduled channels
//   GAP_W           - width of the turnaround counter (GAP_CYC is 1..15)
//   sel_w()         - channel-index width, never below one bit
package mst_pkg;

  localparam int CNT_CHANNLS_DEF = 4;
  localparam int GAP_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } sched_st_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mst_ch_sched_if.sv
// mst_ch_sched_if: channel/PHY handshake bundle of the scheduler.
//   ch_req    - per-channel data-available requests
//   burst_len - beats per grant (0 encodes 2^WIDTH_BURST)
//   rd_rdy    - PHY delivers one beat this cycle
//   seq_err   - per-channel sequence-error flags from the checker
//   rd_req    - read request toward the PHY
//   ch_sel    - index of the granted channel
//   ch_vld    - one-hot beat-valid strobe toward the checker
//   busy      - scheduler is not idle
// master: the scheduler side; slave: the environment driving requests.
interface mst_ch_sched_if
  import mst_pkg::*;
#(
  parameter int CNT_CHANNLS = CNT_CHANNLS_DEF,
  parameter int WIDTH_BURST = 8
);
  localparam int SEL_W = sel_w(CNT_CHANNLS);

  logic                   ch_req [CNT_CHANNLS];
  logic [WIDTH_BURST-1:0] burst_len;
  logic                   rd_rdy;
  logic [CNT_CHANNLS-1:0] seq_err;
  logic                   rd_req;
  logic [SEL_W-1:0]       ch_sel;
  logic                   ch_vld [CNT_CHANNLS];
  logic                   busy;

  modport master (
    input  ch_req, burst_len, rd_rdy, seq_err,
    output rd_req, ch_sel, ch_vld, busy
  );

  modport slave (
    output ch_req, burst_len, rd_rdy, seq_err,
    input  rd_req, ch_sel, ch_vld, busy
  );

endinterface

// File: rtl/mst_ch_sched_rr_arb.sv
// mst_rr_arb: combinational round-robin search.
//   req   - eligible requesters
//   start - index searched first; the search wraps modulo CNT_CHANNLS
//   grant - first eligible index found from start
//   found - at least one requester was eligible
module mst_rr_arb
  import mst_pkg::*;
#(
  parameter int CNT_CHANNLS = CNT_CHANNLS_DEF,
  parameter int SEL_W       = sel_w(CNT_CHANNLS)
) (
  input  logic [CNT_CHANNLS-1:0] req,
  input  logic [SEL_W-1:0]       start,
  output logic [SEL_W-1:0]       grant,
  output logic                   found
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int i = 0; i < CNT_CHANNLS; i++) begin
      idx = int'(start) + i;
      if (idx >= CNT_CHANNLS) idx = idx - CNT_CHANNLS;
      idx_s = SEL_W'(idx);
      if (!found && req[idx_s]) begin
        found = 1'b1;
        grant = idx_s;
      end
    end
  end

endmodule

// File: rtl/mst_ch_sched.sv
// mst_ch_sched: round-robin burst scheduler for streaming read channels.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - mst_ch_sched_if.master (requests, burst length, PHY handshake,
//           grant index, beat strobes, busy)
// Flow: IDLE -> ARB (one cycle, grant + latch length) -> XFER (beats) ->
// GAP (GAP_CYC idle turnaround cycles) -> IDLE.
// Optional feature, macro MST_CH_SCHED_ERR_SKIP_EN: channels flagging
// seq_err are not eligible, and a seq_err on the active channel ends its
// burst. Without the macro seq_err is ignored.
module mst_ch_sched
  import mst_pkg::*;
#(
  parameter int CNT_CHANNLS = CNT_CHANNLS_DEF,
  parameter int WIDTH_BURST = 8,
  parameter int GAP_CYC     = 2
) (
  input logic            clk,
  input logic            rst_n,
  mst_ch_sched_if.master bus
);

  localparam int SEL_W = sel_w(CNT_CHANNLS);

  sched_st_t              state;
  logic [SEL_W-1:0]       last_grant;
  logic [SEL_W-1:0]       ch_sel_q;
  logic [SEL_W-1:0]       arb_start;
  logic [SEL_W-1:0]       arb_grant;
  logic                   arb_found;
  logic [CNT_CHANNLS-1:0] elig;
  // One extra bit so a length of 2^WIDTH_BURST is representable.
  logic [WIDTH_BURST:0]   len_q;
  logic [WIDTH_BURST:0]   beat_cnt;
  logic [WIDTH_BURST:0]   beat_nxt;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   cur_req;
  logic                   err_exit;

  always_comb begin
    elig = '0;
    for (int i = 0; i < CNT_CHANNLS; i++) begin
`ifdef MST_CH_SCHED_ERR_SKIP_EN
      elig[i] = bus.ch_req[i] & ~bus.seq_err[i];
`else
      elig[i] = bus.ch_req[i];
`endif
    end
  end

`ifdef MST_CH_SCHED_ERR_SKIP_EN
  // The active channel had seq_err low when granted, so a high level now
  // means it rose during the burst.
  assign err_exit = bus.seq_err[ch_sel_q];
`else
  logic unused_seq_err;
  assign unused_seq_err = ^bus.seq_err;
  assign err_exit       = 1'b0;
`endif

  assign arb_start = (last_grant == SEL_W'(CNT_CHANNLS - 1)) ? '0 : last_grant + 1'b1;
  assign cur_req   = bus.ch_req[ch_sel_q];
  assign beat_nxt  = beat_cnt + 1'b1;

  mst_rr_arb #(
    .CNT_CHANNLS (CNT_CHANNLS),
    .SEL_W       (SEL_W)
  ) u_arb (
    .req   (elig),
    .start (arb_start),
    .grant (arb_grant),
    .found (arb_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SEL_W'(CNT_CHANNLS - 1);
      ch_sel_q   <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (|elig) state <= ARB;
        ARB: begin
          if (arb_found) begin
            ch_sel_q   <= arb_grant;
            last_grant <= arb_grant;
            len_q      <= (bus.burst_len == '0) ? {1'b1, {WIDTH_BURST{1'b0}}}
                                                : {1'b0, bus.burst_len};
            beat_cnt   <= '0;
            state      <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (bus.rd_rdy) beat_cnt <= beat_nxt;
          // A beat arriving as ch_req drops is still counted; the exit on a
          // dropped request waits for a cycle without a beat.
          if (err_exit || (bus.rd_rdy && beat_nxt == len_q) ||
              (!cur_req && !bus.rd_rdy)) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_req = (state == XFER);
  assign bus.busy   = (state != IDLE);
  assign bus.ch_sel = ch_sel_q;

  always_comb begin
    for (int i = 0; i < CNT_CHANNLS; i++) begin
      bus.ch_vld[i] = (state == XFER) && bus.rd_rdy && (ch_sel_q == SEL_W'(i));
    end
  end

endmodule

// File: tb/tb_mst_ch_sched.sv
// tb_mst_ch_sched: directed bench for mst_ch_sched with 4 channels,
// 8-bit burst length and 2 gap cycles. Define MST_CH_SCHED_ERR_SKIP_EN for
// both bench and RTL to exercise the error-skip scenario as well.
module tb_mst_ch_sched;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mst_ch_sched_if #(.CNT_CHANNLS(4), .WIDTH_BURST(8)) bus ();

  mst_ch_sched #(
    .CNT_CHANNLS (4),
    .WIDTH_BURST (8),
    .GAP_CYC     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] vld_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = bus.ch_vld[i];
    return v;
  endfunction

  task automatic set_req(input logic [3:0] r);
    for (int i = 0; i < 4; i++) bus.ch_req[i] = r[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, check the idle outputs, release reset in an IDLE window.
  task automatic reset_dut();
    rst_n         = 1'b0;
    set_req(4'b0000);
    bus.burst_len = '0;
    bus.rd_rdy    = 1'b1;
    bus.seq_err   = '0;
    tick();
    tick();
    #1;
    chk_eq("rst_busy",   32'(bus.busy),   32'd0);
    chk_eq("rst_rd_req", 32'(bus.rd_req), 32'd0);
    chk_eq("rst_ch_vld", 32'(vld_vec()),  32'd0);
    chk_eq("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
    rst_n      = 1'b1;
    bus.rd_rdy = 1'b0;
  endtask

  // Advance until rd_req is seen (bounded); leaves the bench in that window.
  task automatic wait_rdreq(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.rd_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk_eq(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [3:0] v;
    int         n2;
    int         nother;
    logic       seen;
    logic       done;
    int         g;

    rst_n = 1'b0;
    set_req(4'b0000);
    bus.burst_len = '0;
    bus.rd_rdy    = 1'b0;
    bus.seq_err   = '0;

    // All channels requesting, length 4, PHY always ready: 8-cycle period
    // IDLE, ARB, 4x XFER, 2x GAP; grants rotate 0,1,2,3,0. rd_rdy high
    // outside XFER must not strobe.
    reset_dut();
    set_req(4'b1111);
    bus.burst_len = 8'd4;
    bus.rd_rdy    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      for (int c = 0; c < 8; c++) begin
        #1;
        chk_eq($sformatf("s1_busy_k%0d_c%0d", k, c), 32'(bus.busy), (c != 0) ? 32'd1 : 32'd0);
        chk_eq($sformatf("s1_rdreq_k%0d_c%0d", k, c), 32'(bus.rd_req),
               (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
        chk_eq($sformatf("s1_vld_k%0d_c%0d", k, c), 32'(vld_vec()),
               (c >= 2 && c <= 5) ? (32'd1 << g) : 32'd0);
        if (c == 2) chk_eq($sformatf("s1_sel_k%0d", k), 32'(bus.ch_sel), 32'(g));
        tick();
      end
    end

    // Only channel 2, burst_len 0 -> 256 beats before the GAP.
    reset_dut();
    set_req(4'b0100);
    bus.burst_len = 8'd0;
    bus.rd_rdy    = 1'b1;
    n2 = 0; nother = 0; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      #1;
      v = vld_vec();
      if (bus.rd_req) begin
        seen = 1'b1;
        if (v == 4'b0100) n2++;
        else nother++;
      end else if (seen) begin
        done = 1'b1;
      end
      if (!done) tick();
    end
    chk_eq("s2_done",   32'(done),     32'd1);
    chk_eq("s2_beats",  32'(n2),       32'd256);
    chk_eq("s2_other",  32'(nother),   32'd0);
    chk_eq("s2_gap",    32'(bus.busy), 32'd1);
    set_req(4'b0000);

    // Channel 1, length 10: three beats, then request drops with rd_rdy low.
    reset_dut();
    bus.burst_len = 8'd10;
    bus.rd_rdy    = 1'b0;
    set_req(4'b0010);
    wait_rdreq("s3_grant");
    chk_eq("s3_sel", 32'(bus.ch_sel), 32'd1);
    for (int b = 0; b < 3; b++) begin
      bus.rd_rdy = 1'b1;
      #1;
      chk_eq($sformatf("s3_beat%0d", b), 32'(vld_vec()), 32'b0010);
      tick();
    end
    set_req(4'b0000);
    bus.rd_rdy = 1'b0;
    #1;
    chk_eq("s3_still_xfer", 32'(bus.rd_req), 32'd1);
    chk_eq("s3_no_vld",     32'(vld_vec()),  32'd0);
    tick();
    bus.rd_rdy = 1'b1;
    #1;
    chk_eq("s3_gap_rdreq", 32'(bus.rd_req), 32'd0);
    chk_eq("s3_gap_busy",  32'(bus.busy),   32'd1);
    chk_eq("s3_gap_vld",   32'(vld_vec()),  32'd0);
    tick();
    #1;
    chk_eq("s3_gap2_busy", 32'(bus.busy),  32'd1);
    chk_eq("s3_gap2_vld",  32'(vld_vec()), 32'd0);
    tick();
    #1;
    chk_eq("s3_idle_busy", 32'(bus.busy),  32'd0);
    chk_eq("s3_idle_vld",  32'(vld_vec()), 32'd0);

    // last_grant is 1 now, so the next grant goes to channel 2; reset after
    // beat 2 must restore channel 0 as the next winner.
    set_req(4'b1111);
    bus.burst_len = 8'd4;
    bus.rd_rdy    = 1'b1;
    tick();
    #1;
    chk_eq("s4_arb_busy",  32'(bus.busy),   32'd1);
    chk_eq("s4_arb_rdreq", 32'(bus.rd_req), 32'd0);
    tick();
    #1;
    chk_eq("s4_sel",   32'(bus.ch_sel), 32'd2);
    chk_eq("s4_beat1", 32'(vld_vec()),  32'b0100);
    tick();
    #1;
    chk_eq("s4_beat2", 32'(vld_vec()),  32'b0100);
    tick();
    rst_n      = 1'b0;
    bus.rd_rdy = 1'b0;
    tick();
    bus.rd_rdy = 1'b1;
    #1;
    chk_eq("s4_rst_busy",  32'(bus.busy),   32'd0);
    chk_eq("s4_rst_rdreq", 32'(bus.rd_req), 32'd0);
    chk_eq("s4_rst_vld",   32'(vld_vec()),  32'd0);
    chk_eq("s4_rst_sel",   32'(bus.ch_sel), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    #1;
    chk_eq("s4_regrant_sel", 32'(bus.ch_sel), 32'd0);
    chk_eq("s4_regrant_vld", 32'(vld_vec()),  32'b0001);
    set_req(4'b0000);

`ifdef MST_CH_SCHED_ERR_SKIP_EN
    // Channel 1 flagged: only channel 0 granted; seq_err[0] mid-burst ends it.
    reset_dut();
    bus.seq_err   = 4'b0010;
    bus.burst_len = 8'd8;
    bus.rd_rdy    = 1'b1;
    set_req(4'b0011);
    wait_rdreq("s5_grant");
    chk_eq("s5_sel", 32'(bus.ch_sel), 32'd0);
    tick();
    bus.seq_err = 4'b0011;
    #1;
    chk_eq("s5_err_beat", 32'(vld_vec()), 32'b0001);
    tick();
    #1;
    chk_eq("s5_err_gap_rdreq", 32'(bus.rd_req), 32'd0);
    chk_eq("s5_err_gap_busy",  32'(bus.busy),   32'd1);
    bus.seq_err = 4'b0010;
    tick();
    wait_rdreq("s5_regrant");
    chk_eq("s5_regrant_sel", 32'(bus.ch_sel), 32'd0);
    set_req(4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mst_ch_sched.md
MST_CH_SCHED -- requirements
Module: mst_ch_sched

Interface
REQ-001 Parameter CNT_CHANNLS, default 4: number of streaming channels scheduled.
REQ-002 Parameter WIDTH_BURST, default 8: width of burst_len and the beat counter.
REQ-003 Parameter GAP_CYC, default 2: number of idle turnaround cycles after each burst, range 1..15.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port ch_req, input, unpacked [CNT_CHANNLS] x 1: channel n has data available.
REQ-007 Port burst_len, input, WIDTH_BURST: beats per grant; sampled at grant; 0 means 2^WIDTH_BURST.
REQ-008 Port rd_rdy, input, 1: the PHY delivers one data beat this cycle.
REQ-009 Port seq_err, input, CNT_CHANNLS: per-channel sequence-error flags from the data checker.
REQ-010 Port rd_req, output, 1: read request to the PHY.
REQ-011 Port ch_sel, output, $clog2(CNT_CHANNLS): index of the granted channel.
REQ-012 Port ch_vld, output, unpacked [CNT_CHANNLS] x 1: one-hot beat-valid strobe toward the checker.
REQ-013 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 The scheduler SHALL implement states IDLE, ARB, XFER and GAP.
REQ-015 IDLE SHALL go to ARB when any eligible ch_req is high.
REQ-016 IDLE SHALL stay in IDLE when no eligible ch_req is high.
REQ-017 ARB SHALL last exactly one cycle.
REQ-018 ARB SHALL grant round-robin: search starts at last_grant+1 modulo CNT_CHANNLS, and the first eligible requester wins.
REQ-019 ARB SHALL latch ch_sel and burst_len, clear beat_cnt and enter XFER.
REQ-020 If no request remains in ARB, the block SHALL return to IDLE without a grant, and last_grant SHALL be unchanged.
REQ-021 In XFER, rd_req SHALL be 1 combinationally from the state.
REQ-022 ch_vld[ch_sel] SHALL equal rd_rdy while in XFER.
REQ-023 All other ch_vld bits SHALL be 0, and all ch_vld bits SHALL be 0 outside XFER.
REQ-024 beat_cnt SHALL increment on each rd_rdy in XFER.
REQ-025 XFER SHALL exit to GAP on the beat where beat_cnt+1 equals the latched length.
REQ-026 XFER SHALL also exit to GAP in any cycle where ch_req[ch_sel] is low and rd_rdy is low.
REQ-027 A beat accepted in the same cycle that ch_req drops SHALL be counted and strobed before the exit.
REQ-028 GAP SHALL hold rd_req=0 for exactly GAP_CYC cycles, then go to IDLE.
REQ-029 ch_req changes during GAP SHALL be ignored.
REQ-030 last_grant SHALL update on the ARB-to-XFER transition only.
REQ-031 rd_rdy outside XFER SHALL be ignored and SHALL produce no ch_vld.
REQ-032 beat_cnt SHALL be WIDTH_BURST+1 bits so that the length 2^WIDTH_BURST does not wrap.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL enter IDLE.
REQ-034 Reset SHALL set last_grant to CNT_CHANNLS-1, so that channel 0 wins first.
REQ-035 Reset SHALL clear beat_cnt and the gap counter and set ch_sel to 0.
REQ-036 After reset, rd_req, busy and all ch_vld SHALL be 0 from the following cycle.
REQ-037 Reset asserted mid-XFER SHALL abort the burst with no further ch_vld strobe.

Configuration
REQ-038 With macro MST_CH_SCHED_ERR_SKIP_EN defined, a channel SHALL be eligible only when ch_req[n] & !seq_err[n].
REQ-039 With MST_CH_SCHED_ERR_SKIP_EN defined, seq_err[ch_sel] rising in XFER SHALL force exit to GAP on the next cycle.
REQ-040 With MST_CH_SCHED_ERR_SKIP_EN undefined, a channel SHALL be eligible when ch_req[n]=1.
REQ-041 With MST_CH_SCHED_ERR_SKIP_EN undefined, seq_err SHALL be unused.

Structure
REQ-042 Package mst_pkg SHALL hold the state enum sched_st_t (IDLE, ARB, XFER, GAP) and the CNT_CHANNLS default constant.
REQ-043 Round-robin selection SHALL be a sub-module mst_rr_arb: combinational search from the start index, outputting a grant index and a found flag.

Verification
REQ-044 Scenario: ch_req=4'b1111 held, burst_len=4, rd_rdy=1 continuously -> grants in order 0,1,2,3,0; each burst gives 4 ch_vld pulses, then 2 GAP cycles.
REQ-045 Scenario: only channel 2 requests, burst_len=0, rd_rdy=1 -> exactly 256 ch_vld[2] pulses; beat_cnt does not wrap early.
REQ-046 Scenario: channel 1 granted with burst_len=10, ch_req[1] drops after beat 3 with rd_rdy low -> GAP entered next cycle with 3 beats counted.
REQ-047 Scenario: rst_n=0 in XFER after beat 2 -> next cycle IDLE, rd_req=0, busy=0, and the next grant goes to channel 0.
REQ-048 Scenario (MST_CH_SCHED_ERR_SKIP_EN defined): seq_err[1]=1 with ch_req=4'b0011 -> only channel 0 is granted; seq_err[0] rising mid-burst -> GAP the next cycle.
REQ-049 Scenario: rd_rdy=1 in IDLE and GAP -> no ch_vld asserted.
